// File: rtl/grid_board_painter.sv
// Tic-tac-toe board engine: owns cells and mouse cursor, places alternating marks,
// scans lines for a win or draw, and paints grid/marks/cursor through a 1-clk font ROM.
module grid_board_painter #(
  parameter int GRID_N    = 3,
  parameter int CELL_W    = 80,
  parameter int ORIGIN_X  = 150,
  parameter int ORIGIN_Y  = 100,
  parameter int BAR_W     = 2,
  parameter int CURSOR_SZ = 15,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_tick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [8:0]  mouse_dx,
  input  logic [8:0]  mouse_dy,
  input  logic        mouse_valid,
  input  logic        btn_left,
  input  logic        clear,
  input  logic [7:0]  font_word,
  output logic [10:0] rom_addr,
  output logic [2:0]  rgb,
  output logic        board_on,
  output logic [1:0]  game_state,
  output logic        turn,
  output logic [1:0]  fsm_state
);
  localparam int NC = GRID_N * GRID_N;
  localparam int CW = $clog2(NC);
  localparam int NL = 2 * GRID_N + 2;
  localparam int LW = $clog2(NL);
  localparam int MW = $clog2(NC + 1);
  localparam logic [9:0] GX0 = 10'((CELL_W - 32) / 2);
  localparam logic [9:0] GY0 = 10'((CELL_W - 64) / 2);
  localparam logic [1:0] PLAYING = 2'd0, X_WIN = 2'd1, O_WIN = 2'd2, DRAW = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} fsm_t;
  typedef struct packed {
    logic       in;
    logic       bar;
    logic [2:0] idx;
    logic [9:0] off;
  } axis_t;

  // Maps one coordinate onto the grid: cell index, offset inside the cell, and bar hit.
  function automatic axis_t locate(input logic [10:0] p, input int origin);
    axis_t r;
    int    rel;
    r = '0;
    for (int k = 0; k < GRID_N; k++) begin
      rel = int'(p) - origin - k * CELL_W;
      if (rel >= 0 && rel < CELL_W) begin
        r.in  = 1'b1;
        r.idx = 3'(k);
        r.off = 10'(rel);
        r.bar = (k != 0) && (rel < BAR_W);
      end
    end
    return r;
  endfunction

  function automatic logic [10:0] acc_add(input logic [10:0] a, input logic [8:0] d);
    logic signed [11:0] s;
    s = $signed({a[10], a}) + $signed({{3{d[8]}}, d});
    if (s > 12'sd1023) return 11'h3FF;
    if (s < -12'sd1023) return 11'h401;
    return s[10:0];
  endfunction

  function automatic logic [9:0] cur_move(input logic [9:0] c, input logic [10:0] a, input int lim);
    logic [11:0] s;
    s = {2'b00, c} + {a[10], a};
    if (s[11]) return '0;
    if (s[10:0] > 11'(lim)) return 10'(lim);
    return s[9:0];
  endfunction

  // mouse_valid is a one-clk strobe with no ready: every strobe is absorbed in its clk.
  logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [10:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic        frame_tick;

  assign frame_tick = pixel_tick && (pix_x == 10'd0) && (pix_y == 10'(SCREEN_H));

  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (frame_tick) begin
      cur_x_d = cur_move(cur_x_q, acc_x_q, SCREEN_W - CURSOR_SZ);
      cur_y_d = cur_move(cur_y_q, acc_y_q, SCREEN_H - CURSOR_SZ);
      acc_x_d = mouse_valid ? {{2{mouse_dx[8]}}, mouse_dx} : '0;
      acc_y_d = mouse_valid ? {{2{mouse_dy[8]}}, mouse_dy} : '0;
    end else if (mouse_valid) begin
      acc_x_d = acc_add(acc_x_q, mouse_dx);
      acc_y_d = acc_add(acc_y_q, mouse_dy);
    end
  end

  logic btn_s1_q, btn_s2_q, btn_prev_q, rise;
  assign rise = btn_s2_q & ~btn_prev_q;

  axis_t hx, hy;
  logic [CW-1:0] hit_cell;
  logic          unused_hit;
  assign hx         = locate({1'b0, cur_x_q} + 11'(CURSOR_SZ / 2), ORIGIN_X);
  assign hy         = locate({1'b0, cur_y_q} + 11'(CURSOR_SZ / 2), ORIGIN_Y);
  assign hit_cell   = CW'(int'(hy.idx) * GRID_N + int'(hx.idx));
  assign unused_hit = ^{hx.off, hy.off};

  fsm_t                state_q, state_d;
  logic [NC-1:0][1:0]  cells_q, cells_d;
  logic [NC-1:0]       win_mask_q, win_mask_d, line_mask;
  logic [LW-1:0]       line_q, line_d;
  logic [MW-1:0]       move_cnt_q, move_cnt_d;
  logic [1:0]          game_state_q, game_state_d;
  logic                turn_q, turn_d, found_q, found_d, winner_q, winner_d;
  logic                x_all, o_all, click_ok;

  // Membership of the line currently under scan: rows, columns, main diag, anti-diag.
  always_comb begin
    line_mask = '0;
    x_all     = 1'b1;
    o_all     = 1'b1;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (int'(line_q) == r || int'(line_q) == GRID_N + c ||
            (int'(line_q) == 2 * GRID_N && r == c) ||
            (int'(line_q) == 2 * GRID_N + 1 && r + c == GRID_N - 1)) begin
          line_mask[r * GRID_N + c] = 1'b1;
          if (cells_q[r * GRID_N + c] != 2'b01) x_all = 1'b0;
          if (cells_q[r * GRID_N + c] != 2'b10) o_all = 1'b0;
        end
      end
    end
  end

  assign click_ok = rise && (game_state_q == PLAYING) && hx.in && hy.in &&
                    !hx.bar && !hy.bar && (cells_q[hit_cell] == 2'b00);

  always_comb begin
    state_d      = state_q;
    cells_d      = cells_q;
    win_mask_d   = win_mask_q;
    line_d       = line_q;
    move_cnt_d   = move_cnt_q;
    game_state_d = game_state_q;
    turn_d       = turn_q;
    found_d      = found_q;
    winner_d     = winner_q;
    case (state_q)
      IDLE: if (click_ok) begin
        cells_d[hit_cell] = {turn_q, ~turn_q};
        turn_d     = ~turn_q;
        move_cnt_d = move_cnt_q + 1'b1;
        line_d     = '0;
        found_d    = 1'b0;
        state_d    = SCAN;
      end
      SCAN: begin
        if (!found_q && (x_all || o_all)) begin
          found_d    = 1'b1;
          winner_d   = o_all;
          win_mask_d = line_mask;
        end
        line_d = line_q + 1'b1;
        if (line_q == LW'(NL - 1)) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (found_q) game_state_d = winner_q ? O_WIN : X_WIN;
        else if (move_cnt_q == MW'(NC)) game_state_d = DRAW;
        else game_state_d = PLAYING;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d      = IDLE;
      cells_d      = '0;
      win_mask_d   = '0;
      line_d       = '0;
      move_cnt_d   = '0;
      game_state_d = PLAYING;
      turn_d       = 1'b0;
      found_d      = 1'b0;
      winner_d     = 1'b0;
    end
  end

  // Paint stage 1: classify the pixel and address the font ROM.
  axis_t         lx, ly;
  logic [CW-1:0] pix_cell;
  logic [1:0]    pix_mark;
  logic [9:0]    gdx, gdy;
  logic          in_grid, in_glyph, on_cursor;
  assign lx        = locate({1'b0, pix_x}, ORIGIN_X);
  assign ly        = locate({1'b0, pix_y}, ORIGIN_Y);
  assign pix_cell  = CW'(int'(ly.idx) * GRID_N + int'(lx.idx));
  assign pix_mark  = cells_q[pix_cell];
  assign gdx       = lx.off - GX0;
  assign gdy       = ly.off - GY0;
  assign in_grid   = lx.in && ly.in;
  assign in_glyph  = (lx.off >= GX0) && (lx.off < GX0 + 10'd32) &&
                     (ly.off >= GY0) && (ly.off < GY0 + 10'd64);
  assign on_cursor = (pix_x >= cur_x_q) && ({1'b0, pix_x} < {1'b0, cur_x_q} + 11'(CURSOR_SZ)) &&
                     (pix_y >= cur_y_q) && ({1'b0, pix_y} < {1'b0, cur_y_q} + 11'(CURSOR_SZ));

  logic [10:0] rom_addr_q;
  logic        cursor_q, bar_q, glyph_q, win_q, inside_q;
  logic [2:0]  bit_q;
  logic [2:0]  rgb_q, rgb_d;
  logic        on_q, on_d;

  always_comb begin
    rgb_d = 3'b000;
    on_d  = 1'b0;
    if (cursor_q) begin
      rgb_d = 3'b010;
      on_d  = 1'b1;
    end else if (bar_q) begin
      rgb_d = 3'b011;
      on_d  = 1'b1;
    end else if (glyph_q && font_word[3'd7 - bit_q]) begin
      rgb_d = win_q ? 3'b110 : 3'b111;
      on_d  = 1'b1;
    end else if (inside_q) begin
      on_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x_q      <= 10'(SCREEN_W / 2);
      cur_y_q      <= 10'(SCREEN_H / 2);
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_prev_q   <= 1'b0;
      state_q      <= IDLE;
      cells_q      <= '0;
      win_mask_q   <= '0;
      line_q       <= '0;
      move_cnt_q   <= '0;
      game_state_q <= PLAYING;
      turn_q       <= 1'b0;
      found_q      <= 1'b0;
      winner_q     <= 1'b0;
      rom_addr_q   <= '0;
      cursor_q     <= 1'b0;
      bar_q        <= 1'b0;
      glyph_q      <= 1'b0;
      win_q        <= 1'b0;
      inside_q     <= 1'b0;
      bit_q        <= '0;
      rgb_q        <= '0;
      on_q         <= 1'b0;
    end else begin
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      btn_s1_q     <= btn_left;
      btn_s2_q     <= btn_s1_q;
      btn_prev_q   <= btn_s2_q;
      state_q      <= state_d;
      cells_q      <= cells_d;
      win_mask_q   <= win_mask_d;
      line_q       <= line_d;
      move_cnt_q   <= move_cnt_d;
      game_state_q <= game_state_d;
      turn_q       <= turn_d;
      found_q      <= found_d;
      winner_q     <= winner_d;
      if (pixel_tick) begin
        rom_addr_q <= {(pix_mark == 2'b10) ? 7'h4F : 7'h58, gdy[5:2]};
        cursor_q   <= on_cursor;
        bar_q      <= in_grid && (lx.bar || ly.bar);
        glyph_q    <= in_grid && !lx.bar && !ly.bar && in_glyph && (pix_mark != 2'b00);
        win_q      <= win_mask_q[pix_cell];
        inside_q   <= in_grid;
        bit_q      <= gdx[4:2];
        rgb_q      <= rgb_d;
        on_q       <= on_d;
      end
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rgb        = rgb_q;
  assign board_on   = on_q;
  assign game_state = game_state_q;
  assign turn       = turn_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_grid_board_painter.sv
// Directed bench for grid_board_painter: pixel probe tables plus hand-timed click,
// clear and reset sequences against a small behavioural font ROM.
module tb_grid_board_painter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixel_tick = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic [8:0]  mouse_dx = '0, mouse_dy = '0;
  logic        mouse_valid = 1'b0, btn_left = 1'b0, clear = 1'b0;
  logic [7:0]  font_word;
  logic [10:0] rom_addr;
  logic [2:0]  rgb;
  logic        board_on, turn;
  logic [1:0]  game_state, fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cx = 320, cy = 240;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] exp;
  } probe_t;

  always #5 clk = ~clk;

  grid_board_painter dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .pix_x(pix_x), .pix_y(pix_y),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_valid(mouse_valid),
    .btn_left(btn_left), .clear(clear), .font_word(font_word), .rom_addr(rom_addr),
    .rgb(rgb), .board_on(board_on), .game_state(game_state), .turn(turn),
    .fsm_state(fsm_state)
  );

  function automatic logic [7:0] font_rom(input logic [10:0] a);
    logic [6:0] ch;
    ch = a[10:4];
    if (ch == 7'h58) return 8'hC3;
    if (ch == 7'h4F) return 8'h3C;
    return 8'h00;
  endfunction

  always @(posedge clk) font_word <= font_rom(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp = {board_on, rgb}
  task automatic probe(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic [3:0] exp);
    pix_x = x; pix_y = y; pixel_tick = 1'b1; tick();
    pixel_tick = 1'b0; tick();
    pixel_tick = 1'b1; tick();
    pixel_tick = 1'b0;
    check(name, {12'd0, board_on, rgb}, {12'd0, exp});
    pix_x = '0; pix_y = '0;
  endtask

  task automatic mouse_pkt(input int dx, input int dy);
    mouse_dx = 9'(dx); mouse_dy = 9'(dy); mouse_valid = 1'b1; tick();
    mouse_valid = 1'b0; mouse_dx = '0; mouse_dy = '0;
  endtask

  task automatic frame();
    pix_x = '0; pix_y = 10'd480; pixel_tick = 1'b1; tick();
    pixel_tick = 1'b0; pix_y = '0;
  endtask

  task automatic move_to(input int tx, input int ty);
    int dx, dy, sx, sy;
    dx = tx - cx; dy = ty - cy;
    while (dx != 0 || dy != 0) begin
      sx = (dx > 255) ? 255 : ((dx < -255) ? -255 : dx);
      sy = (dy > 255) ? 255 : ((dy < -255) ? -255 : dy);
      mouse_pkt(sx, sy);
      dx -= sx; dy -= sy;
    end
    frame();
    cx = tx; cy = ty;
  endtask

  task automatic move_cell(input int k);
    move_to(183 + 80 * (k % 3), 133 + 80 * (k / 3));
  endtask

  task automatic press();
    btn_left = 1'b1; repeat (3) tick();
    btn_left = 1'b0; repeat (12) tick();
  endtask

  task automatic click_cell(input int k);
    move_cell(k);
    press();
  endtask

  probe_t reset_vec[10];
  probe_t win_vec[6];
  int     win_seq[4];
  int     draw_seq[9];

  initial begin
    reset_vec[0] = '{10'd151, 10'd101, 4'b1_000};
    reset_vec[1] = '{10'd231, 10'd150, 4'b1_011};
    reset_vec[2] = '{10'd232, 10'd150, 4'b1_000};
    reset_vec[3] = '{10'd200, 10'd180, 4'b1_011};
    reset_vec[4] = '{10'd10,  10'd10,  4'b0_000};
    reset_vec[5] = '{10'd389, 10'd339, 4'b1_000};
    reset_vec[6] = '{10'd390, 10'd200, 4'b0_000};
    reset_vec[7] = '{10'd320, 10'd240, 4'b1_010};
    reset_vec[8] = '{10'd334, 10'd254, 4'b1_010};
    reset_vec[9] = '{10'd335, 10'd240, 4'b1_000};
    win_vec[0] = '{10'd174, 10'd108, 4'b1_110};
    win_vec[1] = '{10'd254, 10'd108, 4'b1_110};
    win_vec[2] = '{10'd334, 10'd108, 4'b1_110};
    win_vec[3] = '{10'd182, 10'd108, 4'b1_000};
    win_vec[4] = '{10'd182, 10'd188, 4'b1_111};
    win_vec[5] = '{10'd262, 10'd188, 4'b1_111};
    win_seq  = '{0, 3, 1, 4};
    draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    // Reset state
    repeat (3) tick();
    check("rst_rgb", {13'd0, rgb}, 16'd0);
    check("rst_on", {15'd0, board_on}, 16'd0);
    check("rst_addr", {5'd0, rom_addr}, 16'd0);
    check("rst_gs", {14'd0, game_state}, 16'd0);
    check("rst_turn", {15'd0, turn}, 16'd0);
    check("rst_fsm", {14'd0, fsm_state}, 16'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++)
      probe($sformatf("reset_px%0d", i), reset_vec[i].x, reset_vec[i].y, reset_vec[i].exp);

    // Cursor accumulation and clamping
    repeat (3) mouse_pkt(100, 0);
    frame();
    probe("cur_620", 10'd620, 10'd240, 4'b1_010);
    probe("cur_619", 10'd619, 10'd240, 4'b0_000);
    repeat (4) mouse_pkt(-256, 0);
    frame();
    probe("cur_0", 10'd0, 10'd240, 4'b1_010);
    probe("cur_15", 10'd15, 10'd240, 4'b0_000);
    mouse_pkt(20, 0);
    mouse_dx = 9'd50; mouse_valid = 1'b1;
    pix_x = '0; pix_y = 10'd480; pixel_tick = 1'b1; tick();
    pixel_tick = 1'b0; mouse_valid = 1'b0; mouse_dx = '0; pix_y = '0;
    frame();
    probe("cur_seed70", 10'd70, 10'd240, 4'b1_010);
    probe("cur_seed69", 10'd69, 10'd240, 4'b0_000);
    cx = 70; cy = 240;

    // X wins on the top row
    for (int i = 0; i < 4; i++) begin
      click_cell(win_seq[i]);
      exp_q.push_back({1'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
      check($sformatf("win_turn%0d", i), {15'd0, turn}, {14'd0, exp_q.pop_front()});
    end
    move_cell(2);
    btn_left = 1'b1; repeat (3) tick();
    check("final_write_fsm", {14'd0, fsm_state}, 16'd1);
    check("final_write_turn", {15'd0, turn}, 16'd1);
    btn_left = 1'b0;
    repeat (8) tick();
    check("gs_before_9", {14'd0, game_state}, 16'd0);
    tick();
    check("gs_at_9", {14'd0, game_state}, 16'd1);
    repeat (5) tick();
    for (int i = 0; i < 6; i++)
      probe($sformatf("win_px%0d", i), win_vec[i].x, win_vec[i].y, win_vec[i].exp);
    click_cell(5);
    check("post_win_turn", {15'd0, turn}, 16'd1);
    check("post_win_gs", {14'd0, game_state}, 16'd1);
    probe("post_win_cell5", 10'd342, 10'd188, 4'b1_000);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_gs", {14'd0, game_state}, 16'd0);
    check("clear_turn", {15'd0, turn}, 16'd0);
    probe("clear_cell0", 10'd174, 10'd108, 4'b1_000);

    // Draw: X O X / X O O / O X X
    for (int i = 0; i < 9; i++) begin
      click_cell(draw_seq[i]);
      exp_q.push_back({(i == 8) ? 1'b1 : 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
      check($sformatf("draw_state%0d", i), {14'd0, game_state[1], turn},
            {14'd0, exp_q.pop_front()});
    end
    check("draw_gs", {14'd0, game_state}, 16'd3);
    probe("draw_cell8", 10'd334, 10'd268, 4'b1_111);
    probe("draw_cell4", 10'd262, 10'd188, 4'b1_111);
    clear = 1'b1; tick(); clear = 1'b0;

    // Ignored clicks: occupied cell, grid bar, during SCAN
    click_cell(4);
    check("x_on4_turn", {15'd0, turn}, 16'd1);
    click_cell(4);
    check("occupied_turn", {15'd0, turn}, 16'd1);
    probe("occupied_cell4", 10'd254, 10'd188, 4'b1_111);
    move_to(224, 133);
    press();
    check("bar_turn", {15'd0, turn}, 16'd1);
    move_cell(0);
    btn_left = 1'b1; repeat (3) tick();
    btn_left = 1'b0;
    move_cell(8);
    btn_left = 1'b1; repeat (3) tick();
    check("scan_click_fsm", {14'd0, fsm_state}, 16'd1);
    btn_left = 1'b0; repeat (12) tick();
    check("scan_click_turn", {15'd0, turn}, 16'd0);
    probe("scan_click_cell8", 10'd334, 10'd268, 4'b1_000);
    probe("o_on_cell0", 10'd182, 10'd108, 4'b1_111);

    // clear wins over a simultaneous accepted click
    click_cell(8);
    check("x_on8_turn", {15'd0, turn}, 16'd1);
    move_cell(2);
    btn_left = 1'b1; tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0; btn_left = 1'b0;
    repeat (12) tick();
    check("clr_click_turn", {15'd0, turn}, 16'd0);
    check("clr_click_fsm", {14'd0, fsm_state}, 16'd0);
    probe("clr_click_cell2", 10'd334, 10'd108, 4'b1_000);
    probe("clr_click_cell8", 10'd334, 10'd268, 4'b1_000);

    // Asynchronous reset in the middle of a scan
    probe("pre_rst_bar", 10'd231, 10'd150, 4'b1_011);
    btn_left = 1'b1; repeat (3) tick();
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_rgb", {13'd0, rgb}, 16'd0);
    check("arst_on", {15'd0, board_on}, 16'd0);
    check("arst_addr", {5'd0, rom_addr}, 16'd0);
    check("arst_gs", {14'd0, game_state}, 16'd0);
    check("arst_turn", {15'd0, turn}, 16'd0);
    check("arst_fsm", {14'd0, fsm_state}, 16'd0);
    btn_left = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    probe("arst_cursor", 10'd320, 10'd240, 4'b1_010);
    probe("arst_cell2", 10'd334, 10'd108, 4'b1_000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grid_board_painter.md
# grid_board_painter

Parametrised N×N board engine and pixel painter for the tic-tac-toe VGA display. It owns the board state and the mouse cursor. It places alternating X/O marks on mouse clicks and detects win or draw with a sequential line scanner. It also paints the grid, marks, winning line and cursor through the shared 8×16 font ROM. It sits between the PS/2 mouse decoder and the VGA sync/RGB mux, next to the title/label text painter.

## Interface
Parameters:
- GRID_N, 3: cells per side, 3..5
- CELL_W, 80: cell pitch in pixels; must be ≥ 64
- ORIGIN_X, 150: left edge of the grid, in pixels
- ORIGIN_Y, 100: top edge of the grid, in pixels
- BAR_W, 2: grid bar thickness, in pixels
- CURSOR_SZ, 15: cursor square side, in pixels
- SCREEN_W, 640: active display width
- SCREEN_H, 480: active display height

Ports (clock and reset first):
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pixel_tick  in  1  pixel enable; the paint pipeline advances only when this is 1
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- mouse_dx  in  9  signed two's-complement X delta
- mouse_dy  in  9  signed two's-complement Y delta; positive moves the cursor down
- mouse_valid  in  1  one-clk strobe marking a new delta packet
- btn_left  in  1  raw level of the left mouse button (asynchronous)
- clear  in  1  one-clk pulse that restarts the match
- font_word  in  8  font ROM data; synchronous ROM with 1-clk read latency
- rom_addr  out  11  {char[6:0], row[3:0]} address to the font ROM
- rgb  out  3  registered pixel colour
- board_on  out  1  registered; 1 when rgb is driven by this block
- game_state  out  2  0 PLAYING, 1 X_WIN, 2 O_WIN, 3 DRAW
- turn  out  1  player to move: 0 = X, 1 = O

## Operation
- Reset values: rgb 0, board_on 0, rom_addr 0, game_state 0, turn 0. All cells empty, cursor at (SCREEN_W/2, SCREEN_H/2), delta accumulators 0, FSM in IDLE.
- Cell encoding (2 bits): 00 empty, 01 X, 10 O. Cells are indexed r*GRID_N+c.
- Cursor update:
  - Each mouse_valid adds the sign-extended deltas to 11-bit signed accumulators acc_x and acc_y. The accumulators saturate at ±1023.
  - The frame tick is pixel_tick with pix_x==0 and pix_y==SCREEN_H.
  - On the frame tick: cur = clamp(cur + acc, 0, SCREEN_x − CURSOR_SZ) on each axis, then acc ← 0.
  - If mouse_valid coincides with the frame tick, the new delta seeds the fresh accumulator and is not lost.
- Click handling:
  - btn_left passes through a 2-FF synchroniser, then a rising-edge detector.
  - The hit point is the cursor centre, cur + CURSOR_SZ/2.
  - A click is accepted only when all of these hold: FSM in IDLE, game_state PLAYING, hit point strictly inside a cell (not on a bar, not outside the grid), and that cell empty.
  - An accepted click writes the mark {turn, ~turn}, toggles turn, increments move_cnt and enters SCAN.
  - All other clicks are ignored.
- Win FSM: IDLE → SCAN → RESOLVE → IDLE.
  - SCAN checks one line per clk, in this order: GRID_N rows, then GRID_N columns, then the main diagonal, then the anti-diagonal. That is 2·GRID_N+2 clks.
  - A line wins when all its cells are equal and non-empty. The first winning line latches win_mask (one bit per cell) and the winner.
  - RESOLVE sets game_state:
    - winner found: X_WIN or O_WIN;
    - else move_cnt == GRID_N²: DRAW;
    - else: PLAYING.
- clear: in any state, in 1 clk, returns cells, win_mask, move_cnt, turn, game_state and FSM to their reset values. The cursor is kept. clear has priority over a simultaneous click.
- Paint priority, highest first:
  1. Cursor square: GREEN 010
  2. Grid bars: LIGHTBLUE 011. Bars are BAR_W wide at ORIGIN + k·CELL_W for k = 1..GRID_N−1 and span GRID_N·CELL_W.
  3. Mark glyphs: char 0x58 'X' or 0x4F 'O', scaled ×4 (32×64), centred in the cell. Set font bits are YELLOW 110 if the cell's win_mask bit is 1, else WHITE 111.
  4. Anywhere else inside the grid: BLACK, with board_on = 1. Outside the grid: rgb 0, board_on 0.
- Font bit select: font_word[7 − bit], where bit = glyph column index.

## Timing
- Paint pipeline, two stages, each gated by pixel_tick:
  - S1 registers rom_addr, layer select and bit index from pix_x/pix_y.
  - The ROM returns font_word one clk later.
  - S2 registers rgb and board_on.
  - rgb for pixel (x, y) appears two pixel_ticks after that pixel is presented. Downstream sync signals are delayed to match.
- Click to cell written: 3 clks from the raw btn_left edge (synchroniser 2, edge detect 1).
- Board write to game_state valid: 2·GRID_N+3 clks (SCAN + RESOLVE + 1).
- A mark change is visible from the next pixel fetched after the write. No frame buffering.
- The cursor moves only at frame ticks, so there is no tearing within a frame.

## Test plan
- Reset with GRID_N=3: rgb=0, game_state=0, turn=0, cursor=(320,240). Pixel (151,101) → rgb 000 with board_on=1. Pixel (231,150) → rgb 011.
- Send 3 packets of dx=+100, then a frame tick → cursor x=620 (clamped at 625−… i.e. 640−15=625, not 620+). Then dx=−9'sd256 ×4 plus a frame tick → cursor x=0.
- Click cells 0, 3, 1, 4, 2 (X, O, X, O, X) → game_state=1 exactly 9 clks after the final write. Cells 0..2 are painted YELLOW. Further clicks are ignored.
- Fill the board with no winner (X O X / X O O / O X X) → game_state=3 after the 9th move.
- Click an occupied cell, click on a bar at x=231, and click inside the grid during SCAN → board and turn unchanged.
- Assert clear in the same clk as an accepted click edge → board empty, turn=0. Deassert rst_n mid-SCAN → all outputs at reset values immediately.
